// File: rtl/key_commander_pkg.sv
// Shared types for the key commander: command codes, debounce states and a width helper.
package key_commander_pkg;

    typedef enum logic [1:0] {
        CMD_UP    = 2'd0,
        CMD_DOWN  = 2'd1,
        CMD_PAUSE = 2'd2,
        CMD_RESET = 2'd3
    } cmd_t;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } deb_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button channel: 2-flop synchronizer, debounce FSM and its sample counter.
module key_debounce
    import key_commander_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_n,
    output deb_state_t state,
    output logic       press
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    deb_state_t       state_next;
    logic             pressed;
    logic             press_next;

    assign pressed = ~sync[1];

    // The synchronizer idles at the released (high) level so a reset never looks like a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= 2'b11;
            state <= RELEASED;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], key_n};
            state <= state_next;
            cnt   <= cnt_next;
            press <= press_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            RELEASED: begin
                if (pressed) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = CNT_W'(1);
                end
            end
            PRESS_WAIT: begin
                if (!pressed) begin
                    state_next = RELEASED;
                    cnt_next   = '0;
                end else if (cnt >= LAST) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!pressed) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = CNT_W'(1);
                end
            end
            RELEASE_WAIT: begin
                if (pressed) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (cnt >= LAST) begin
                    state_next = RELEASED;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = RELEASED;
                cnt_next   = '0;
            end
        endcase
        press_next = (state == PRESS_WAIT) && (state_next == PRESSED);
    end

endmodule

// File: rtl/key_commander.sv
// Four debounced push-buttons turned into a one-deep valid/ready command stream.
// Optional auto-repeat for UP/DOWN is enabled by defining KEY_AUTOREPEAT_EN.
module key_commander
    import key_commander_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [3:0] KEY,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [1:0] cmd,
    output logic [3:0] key_state,
    output logic       overrun
);

    localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;

    deb_state_t st [4];
    logic [3:0] press;
    logic [3:0] events;
    logic       any_ev;
    cmd_t       sel;
    cmd_t       cmd_q;

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_deb (
            .clk   (CLOCK_50),
            .reset (reset),
            .key_n (KEY[i]),
            .state (st[i]),
            .press (press[i])
        );
    end

    always_comb begin
        key_state = '0;
        for (int i = 0; i < 4; i++) begin
            key_state[i] = (st[i] == PRESSED) || (st[i] == RELEASE_WAIT);
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_T  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] PERIOD_T = CNT_W'(REPEAT_PERIOD);

    logic [CNT_W-1:0] rpt_cnt [2];
    logic [1:0]       rpt_phase;
    logic [1:0]       rpt_fire;

    // The first repeat waits REPEAT_DELAY after entering PRESSED, later ones REPEAT_PERIOD.
    always_comb begin
        rpt_fire = '0;
        for (int i = 0; i < 2; i++) begin
            rpt_fire[i] = (st[i] == PRESSED) &&
                          (rpt_cnt[i] == (rpt_phase[i] ? PERIOD_T : DELAY_T));
        end
    end

    always_ff @(posedge CLOCK_50) begin
        for (int i = 0; i < 2; i++) begin
            if (reset || st[i] != PRESSED) begin
                rpt_cnt[i]   <= '0;
                rpt_phase[i] <= 1'b0;
            end else if (rpt_fire[i]) begin
                rpt_cnt[i]   <= CNT_W'(1);
                rpt_phase[i] <= 1'b1;
            end else begin
                rpt_cnt[i] <= rpt_cnt[i] + CNT_W'(1);
            end
        end
    end

    assign events = press | {2'b00, rpt_fire};
`else
    assign events = press;
`endif

    assign any_ev = |events;

    always_comb begin
        sel = CMD_PAUSE;
        if (events[3]) begin
            sel = CMD_RESET;
        end else if (events[1]) begin
            sel = CMD_DOWN;
        end else if (events[0]) begin
            sel = CMD_UP;
        end
    end

    // A slot freed by a transfer in the same cycle is reused at once, so there is no bubble.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cmd_valid <= 1'b0;
            cmd_q     <= CMD_UP;
            overrun   <= 1'b0;
        end else if (any_ev) begin
            if (!cmd_valid || cmd_ready) begin
                cmd_q     <= sel;
                cmd_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (cmd_ready) begin
            cmd_valid <= 1'b0;
        end
    end

    assign cmd = cmd_q;

endmodule

// File: tb/tb_key_commander.sv
// Directed bench for key_commander with short debounce/repeat parameters.
// Build with KEY_AUTOREPEAT_EN defined to exercise the auto-repeat expectations.
module tb_key_commander;

    localparam int DEB = 4;
    localparam int LAT = DEB + 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] KEY;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic [3:0] key_state;
    logic       overrun;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int start;

    logic [1:0] xfer_cmd [$];
    int         xfer_cyc [$];

    typedef struct {
        logic [3:0] key;
        logic [3:0] exp_state;
        int         exp_n;
        int         exp_cmd;
        int         exp_lat;
    } vec_t;

    vec_t vecs [7];

    key_commander #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8)
    ) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .KEY       (KEY),
        .cmd_ready (cmd_ready),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .key_state (key_state),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cmd_valid && cmd_ready) begin
            xfer_cmd.push_back(cmd);
            xfer_cyc.push_back(cyc);
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [3:0] key, input logic ready);
        KEY       = key;
        cmd_ready = ready;
    endtask

    task automatic doReset();
        reset = 1'b1;
        waitCycles(2);
        reset = 1'b0;
        xfer_cmd.delete();
        xfer_cyc.delete();
    endtask

    function automatic int firstCmd();
        return (xfer_cmd.size() > 0) ? int'(xfer_cmd[0]) : -1;
    endfunction

    function automatic int xferLat(input int idx);
        return (xfer_cyc.size() > idx) ? xfer_cyc[idx] - start : -1;
    endfunction

    initial begin
        vecs[0] = '{4'b1110, 4'b0001, 1, 0, LAT};
        vecs[1] = '{4'b1101, 4'b0010, 1, 1, LAT};
        vecs[2] = '{4'b1011, 4'b0100, 1, 2, LAT};
        vecs[3] = '{4'b0111, 4'b1000, 1, 3, LAT};
        vecs[4] = '{4'b0110, 4'b1001, 1, 3, LAT};
        vecs[5] = '{4'b1100, 4'b0011, 1, 1, LAT};
        vecs[6] = '{4'b1010, 4'b0101, 1, 0, LAT};

        KEY       = 4'hF;
        cmd_ready = 1'b1;
        reset     = 1'b1;
        @(posedge clk);
        #2;
        waitCycles(2);
        checkOutput("reset_cmd_valid", int'(cmd_valid), 0);
        checkOutput("reset_cmd", int'(cmd), 0);
        checkOutput("reset_key_state", int'(key_state), 0);
        checkOutput("reset_overrun", int'(overrun), 0);
        reset = 1'b0;

        for (int v = 0; v < 7; v++) begin
            doReset();
            start = cyc;
            applyStimulus(vecs[v].key, 1'b1);
            waitCycles(10);
            checkOutput($sformatf("vec%0d_key_state", v), int'(key_state), int'(vecs[v].exp_state));
            applyStimulus(4'hF, 1'b1);
            waitCycles(12);
            checkOutput($sformatf("vec%0d_count", v), xfer_cmd.size(), vecs[v].exp_n);
            checkOutput($sformatf("vec%0d_cmd", v), firstCmd(), vecs[v].exp_cmd);
            checkOutput($sformatf("vec%0d_latency", v), xferLat(0), vecs[v].exp_lat);
            checkOutput($sformatf("vec%0d_overrun", v), int'(overrun), 0);
            checkOutput($sformatf("vec%0d_released", v), int'(key_state), 0);
        end

        // Bounce on KEY[1], then a clean hold.
        doReset();
        for (int k = 0; k < 10; k++) begin
            applyStimulus((k % 2 == 0) ? 4'b1101 : 4'b1111, 1'b1);
            waitCycles(2);
        end
        checkOutput("bounce_no_cmd", xfer_cmd.size(), 0);
        checkOutput("bounce_key_state", int'(key_state), 0);
        start = cyc;
        applyStimulus(4'b1101, 1'b1);
        waitCycles(10);
        applyStimulus(4'hF, 1'b1);
        waitCycles(12);
        checkOutput("bounce_count", xfer_cmd.size(), 1);
        checkOutput("bounce_cmd", firstCmd(), 1);
        checkOutput("bounce_latency", xferLat(0), LAT);

        // Overrun: UP held in the buffer while PAUSE arrives.
        doReset();
        applyStimulus(4'b1110, 1'b0);
        waitCycles(10);
        applyStimulus(4'hF, 1'b0);
        waitCycles(10);
        applyStimulus(4'b1011, 1'b0);
        waitCycles(10);
        applyStimulus(4'hF, 1'b0);
        waitCycles(10);
        checkOutput("ovr_valid_held", int'(cmd_valid), 1);
        checkOutput("ovr_cmd_held", int'(cmd), 0);
        checkOutput("ovr_flag", int'(overrun), 1);
        checkOutput("ovr_no_xfer", xfer_cmd.size(), 0);
        applyStimulus(4'hF, 1'b1);
        waitCycles(1);
        checkOutput("ovr_drain_count", xfer_cmd.size(), 1);
        checkOutput("ovr_drain_cmd", firstCmd(), 0);
        waitCycles(10);
        checkOutput("ovr_no_pause", xfer_cmd.size(), 1);
        checkOutput("ovr_valid_low", int'(cmd_valid), 0);
        checkOutput("ovr_sticky", int'(overrun), 1);

        // Reset two clocks into PRESS_WAIT while KEY[0] stays low.
        doReset();
        applyStimulus(4'b1110, 1'b1);
        waitCycles(5);
        reset = 1'b1;
        waitCycles(3);
        checkOutput("midrst_valid", int'(cmd_valid), 0);
        checkOutput("midrst_key_state", int'(key_state), 0);
        checkOutput("midrst_no_xfer", xfer_cmd.size(), 0);
        start = cyc;
        reset = 1'b0;
        waitCycles(10);
        applyStimulus(4'hF, 1'b1);
        waitCycles(12);
        checkOutput("midrst_count", xfer_cmd.size(), 1);
        checkOutput("midrst_cmd", firstCmd(), 0);
        checkOutput("midrst_latency", xferLat(0), LAT);

        // Long hold of KEY[0].
        doReset();
        start = cyc;
        applyStimulus(4'b1110, 1'b1);
        waitCycles(40);
        applyStimulus(4'hF, 1'b1);
        waitCycles(12);
        checkOutput("hold_first_latency", xferLat(0), LAT);
        checkOutput("hold_first_cmd", firstCmd(), 0);
`ifdef KEY_AUTOREPEAT_EN
        checkOutput("hold_at_least_3", (xfer_cmd.size() >= 3) ? 1 : 0, 1);
        checkOutput("hold_rpt1_offset", xferLat(1) - xferLat(0), 20);
        checkOutput("hold_rpt2_offset", xferLat(2) - xferLat(0), 28);
        checkOutput("hold_rpt1_cmd", (xfer_cmd.size() > 1) ? int'(xfer_cmd[1]) : -1, 0);
`else
        checkOutput("hold_single", xfer_cmd.size(), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/key_commander.md
KEY_COMMANDER -- requirements
Module: key_commander

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, sets the stable-input time in clocks (10 ms at 50 MHz).
REQ-002 Parameter REPEAT_DELAY, default 25000000, sets the hold time in clocks before the first auto-repeat.
REQ-003 Parameter REPEAT_PERIOD, default 5000000, sets the clocks between auto-repeats.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 CLOCK_50  input  1  sole system clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 KEY  input  4  raw asynchronous push-buttons; active-low (0 = pressed).
REQ-008 cmd_ready  input  1  consumer accepts cmd this cycle.
REQ-009 cmd_valid  output  1  a command is pending.
REQ-010 cmd  output  2  command code: RESET=KEY[3], PAUSE=KEY[2], DOWN=KEY[1], UP=KEY[0].
REQ-011 key_state  output  4  debounced level per key; active-high (1 = pressed).
REQ-012 overrun  output  1  sticky flag; a command was dropped.

Function
REQ-013 Each KEY bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Each key SHALL have its own debounce FSM with states RELEASED, PRESS_WAIT, PRESSED and RELEASE_WAIT.
REQ-015 RELEASED->PRESS_WAIT on a synchronized press; PRESS_WAIT->PRESSED after DEBOUNCE_CYCLES consecutive pressed samples; a released sample returns it to RELEASED and clears the counter.
REQ-016 PRESSED->RELEASE_WAIT on a released sample; RELEASE_WAIT->RELEASED after DEBOUNCE_CYCLES consecutive released samples; a pressed sample returns it to PRESSED.
REQ-017 key_state[i] SHALL be 1 exactly while FSM i is in PRESSED or RELEASE_WAIT.
REQ-018 A press event is the cycle in which FSM i enters PRESSED from PRESS_WAIT; a bounce during release SHALL NOT create a new event.
REQ-019 cmd_valid SHALL rise in the cycle after the press event; latency from a clean KEY edge to cmd_valid is DEBOUNCE_CYCLES+3 clocks.
REQ-020 Handshake: the command transfers in a cycle where cmd_valid and cmd_ready are both 1; cmd_valid and cmd SHALL hold stable until that cycle.
REQ-021 The pending buffer holds one entry; when cmd_valid&cmd_ready occurs together with a new event, the new command loads and cmd_valid stays 1 (zero-bubble).
REQ-022 An event arriving while the buffer is full and not draining SHALL be dropped and SHALL set overrun, which stays set until reset.
REQ-023 Simultaneous events in one cycle SHALL be resolved by priority RESET > DOWN > UP > PAUSE; the lower-priority events are discarded without setting overrun.
REQ-024 Counter widths SHALL be $clog2 of the largest parameter + 1; counters saturate and never wrap.

Reset
REQ-025 While reset is asserted: all FSMs go to RELEASED, counters and synchronizers clear to the released level, cmd_valid=0, cmd=0, key_state=0, overrun=0.
REQ-026 A reset in mid-debounce or with a pending command SHALL discard all state; a key still held after reset releases SHALL need a full DEBOUNCE_CYCLES before producing an event.

Configuration
REQ-027 With macro KEY_AUTOREPEAT_EN defined, holding UP or DOWN in PRESSED for REPEAT_DELAY clocks SHALL produce a further press event, then one every REPEAT_PERIOD clocks until the key leaves PRESSED; RESET and PAUSE never repeat.
REQ-028 With KEY_AUTOREPEAT_EN undefined, each press SHALL give exactly one event, and the repeat counters and parameters SHALL have no hardware effect.

Structure
REQ-029 Package key_commander_pkg SHALL hold the cmd_t enum (CMD_UP=0, CMD_DOWN=1, CMD_PAUSE=2, CMD_RESET=3) and the debounce-state enum.
REQ-030 Sub-module key_debounce holds one synchronizer, FSM and counter, and SHALL be instantiated 4 times; the priority logic, buffer and auto-repeat stay in the top module.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, cmd_ready=1 unless stated)
REQ-031 KEY=1110 held for 10 clocks -> key_state=0001 and one cmd_valid pulse with cmd=CMD_UP 7 clocks after the edge.
REQ-032 KEY[1] toggling every 2 clocks for 20 clocks, then held low -> no command during the bounce; exactly one CMD_DOWN after the hold.
REQ-033 cmd_ready=0 with a press of KEY[0] and then KEY[2] -> cmd=CMD_UP held, overrun=1; after cmd_ready=1 the UP transfers and no PAUSE command appears.
REQ-034 KEY=0110 in the same cycle -> exactly one CMD_RESET; no UP command and overrun=0.
REQ-035 Reset asserted 2 clocks into PRESS_WAIT with KEY[0] kept low -> no command during reset; CMD_UP appears DEBOUNCE_CYCLES+3 clocks after reset releases.
REQ-036 KEY[0] held 40 clocks -> with KEY_AUTOREPEAT_EN, the initial UP plus repeats 20 and 28 clocks after it; without the macro, exactly one UP.
